// File: rtl/imem_boot_ctrl_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encoding and the
// reset value presented on the fetch data port.
package imem_boot_ctrl_pkg;

    typedef enum logic [1:0] {
        S_LEN  = 2'd0,
        S_DATA = 2'd1,
        S_RUN  = 2'd2
    } boot_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/imem_boot_ctrl_byte_asm.sv
// Little-endian byte-to-word assembler; word/word_valid are presented combinationally
// with the 4th byte so the word can be written in the cycle that byte arrives.
module imem_boot_ctrl_byte_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        busy
);

    logic [1:0]  cnt;
    // Only the three earlier bytes need storing; the 4th is taken straight from byte_in.
    logic [23:0] sr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= 2'd0;
            sr  <= 24'd0;
        end else if (byte_valid) begin
            cnt <= cnt + 2'd1;
            sr  <= {byte_in, sr[23:8]};
        end
    end

    assign word       = {byte_in, sr};
    assign word_valid = byte_valid && (cnt == 2'd3);
    assign busy       = (cnt != 2'd0);

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot loader + instruction memory: receives a length-prefixed byte image into BRAM while
// holding the core in reset, then serves fetches with one cycle of read latency.
module imem_boot_ctrl
    import imem_boot_ctrl_pkg::*;
#(
    parameter int AW      = 14,
    parameter int TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        reload,
    output logic        core_rst,
    input  logic [15:0] imem_addr,
    input  logic        imem_oe,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    output logic        load_err
);

    localparam int DEPTH = 2 ** AW;

    boot_state_t state;
    logic [31:0] len;
    logic [31:0] wcnt;
    logic        abort;
    logic        byte_valid;
    logic [31:0] word;
    logic        word_valid;
    logic        asm_busy;
    logic        armed;
    logic        we;
    logic        unused_addr_bits;

    logic [31:0] mem [DEPTH];

    // reload wins over a coincident byte; the loader is deaf once running
    assign byte_valid = rx_valid && !reload && (state != S_RUN);

    imem_boot_ctrl_byte_asm u_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (reload || abort),
        .byte_in   (rx_data),
        .byte_valid(byte_valid),
        .word      (word),
        .word_valid(word_valid),
        .busy      (asm_busy)
    );

    assign armed = ((state == S_LEN) && asm_busy) || (state == S_DATA);

    generate
        if (TIMEOUT > 0) begin : g_wdog
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] idle_cnt;

            always_ff @(posedge clk) begin
                if (rst || reload || !armed || rx_valid)
                    idle_cnt <= '0;
                else
                    idle_cnt <= idle_cnt + 1'b1;
            end

            // fires on the TIMEOUT-th consecutive idle cycle
            assign abort = armed && !rx_valid && !reload && (idle_cnt == CW'(TIMEOUT - 1));
        end else begin : g_no_wdog
            assign abort = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_LEN;
            core_rst   <= 1'b1;
            imem_ready <= 1'b0;
            load_err   <= 1'b0;
            len        <= 32'd0;
            wcnt       <= 32'd0;
        end else if (reload || abort) begin
            state      <= S_LEN;
            core_rst   <= 1'b1;
            imem_ready <= 1'b0;
            len        <= 32'd0;
            wcnt       <= 32'd0;
            if (!reload)
                load_err <= 1'b1;
        end else begin
            case (state)
                S_LEN: begin
                    if (word_valid) begin
                        len      <= word;
                        wcnt     <= 32'd0;
                        load_err <= 1'b0;
                        if (word == 32'd0) begin
                            state      <= S_RUN;
                            core_rst   <= 1'b0;
                            imem_ready <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (word_valid) begin
                        wcnt <= wcnt + 32'd1;
                        if (wcnt == len - 32'd1) begin
                            state      <= S_RUN;
                            core_rst   <= 1'b0;
                            imem_ready <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                end
                default: begin
                    state      <= S_LEN;
                    core_rst   <= 1'b1;
                    imem_ready <= 1'b0;
                end
            endcase
        end
    end

    // Words beyond the array are consumed but not written; no wrap.
    assign we = word_valid && (state == S_DATA) && ((wcnt >> AW) == 32'd0);

    always_ff @(posedge clk) begin
        if (we)
            mem[wcnt[AW-1:0]] <= word;
    end

    // Holds when imem_oe=0 so the core can stall in ID without re-fetching.
    always_ff @(posedge clk) begin
        if (rst)
            imem_rdata <= NOP;
        else if (imem_oe)
            imem_rdata <= mem[imem_addr[2 +: AW]];
    end

    assign unused_addr_bits = ^imem_addr;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed-vector bench for imem_boot_ctrl with a shortened watchdog.
module tb_imem_boot_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        reload;
    logic        core_rst;
    logic [15:0] imem_addr;
    logic        imem_oe;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        load_err;

    int n_tests = 0;
    int n_fail  = 0;

    imem_boot_ctrl #(.AW(14), .TIMEOUT(100)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .reload    (reload),
        .core_rst  (core_rst),
        .imem_addr (imem_addr),
        .imem_oe   (imem_oe),
        .imem_rdata(imem_rdata),
        .imem_ready(imem_ready),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++)
            send_byte(w[8*i +: 8]);
    endtask

    task automatic fetch(input logic [15:0] a);
        imem_addr = a;
        imem_oe   = 1'b1;
        tick(1);
        imem_oe   = 1'b0;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick(1);
        reload = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; reload = 1'b0;
        imem_addr = 16'h0; imem_oe = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);

        // reset state
        check("rst_core_rst", {31'd0, core_rst}, 32'd1);
        check("rst_ready",    {31'd0, imem_ready}, 32'd0);
        check("rst_rdata",    imem_rdata, 32'h0000_0013);
        check("rst_load_err", {31'd0, load_err}, 32'd0);

        // 1: two-word image; core_rst falls one cycle after the final byte
        send_word(32'd2);
        send_word(32'h0000_0093);
        send_byte(8'h13); send_byte(8'h01); send_byte(8'h10);
        check("t1_core_rst_before_last", {31'd0, core_rst}, 32'd1);
        send_byte(8'h00);
        check("t1_core_rst_after_last", {31'd0, core_rst}, 32'd0);
        check("t1_ready", {31'd0, imem_ready}, 32'd1);
        fetch(16'h0004);
        check("t1_fetch_w1", imem_rdata, 32'h0010_0113);
        fetch(16'h0000);
        check("t1_fetch_w0", imem_rdata, 32'h0000_0093);

        // 3: rdata holds while imem_oe=0; low address bits ignored
        fetch(16'h0000);
        for (int i = 0; i < 3; i++) begin
            imem_addr = 16'h0004;
            tick(1);
            check("t3_hold_rdata", imem_rdata, 32'h0000_0093);
            check("t3_hold_ready", {31'd0, imem_ready}, 32'd1);
        end
        fetch(16'h0007);
        check("t3_lowbits_ignored", imem_rdata, 32'h0010_0113);

        // 5: reload with a coincident byte; that byte must not be counted
        rx_data = 8'h55; rx_valid = 1'b1; reload = 1'b1;
        tick(1);
        rx_valid = 1'b0; reload = 1'b0;
        check("t5_core_rst", {31'd0, core_rst}, 32'd1);
        check("t5_ready", {31'd0, imem_ready}, 32'd0);
        send_word(32'd1);
        send_word(32'hDEAD_BEEF);
        check("t5_core_rst_run", {31'd0, core_rst}, 32'd0);
        fetch(16'h0000);
        check("t5_w0_overwritten", imem_rdata, 32'hDEAD_BEEF);
        fetch(16'h0004);
        check("t5_w1_kept", imem_rdata, 32'h0010_0113);

        // 2: empty image goes straight to run, memory untouched
        pulse_reload();
        send_word(32'd0);
        check("t2_core_rst", {31'd0, core_rst}, 32'd0);
        check("t2_ready", {31'd0, imem_ready}, 32'd1);
        fetch(16'h0000);
        check("t2_w0_unchanged", imem_rdata, 32'hDEAD_BEEF);

        // 4: watchdog after 6 bytes and exactly 100 idle cycles
        pulse_reload();
        send_word(32'd1);
        send_byte(8'hAA); send_byte(8'hBB);
        tick(99);
        check("t4_err_at_99", {31'd0, load_err}, 32'd0);
        tick(1);
        check("t4_err_at_100", {31'd0, load_err}, 32'd1);
        check("t4_core_rst", {31'd0, core_rst}, 32'd1);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
        check("t4_err_before_len", {31'd0, load_err}, 32'd1);
        send_byte(8'h00);
        check("t4_err_cleared", {31'd0, load_err}, 32'd0);
        send_word(32'hCAFE_F00D);
        send_word(32'h1234_5678);
        check("t4_core_rst_run", {31'd0, core_rst}, 32'd0);
        fetch(16'h0000);
        check("t4_w0", imem_rdata, 32'hCAFE_F00D);
        fetch(16'h0004);
        check("t4_w1", imem_rdata, 32'h1234_5678);

        // 6: rst mid-load keeps memory, restarts counters
        pulse_reload();
        send_word(32'd5);
        send_word(32'hA000_0000);
        send_word(32'hA000_0001);
        send_word(32'hA000_0002);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t6_core_rst", {31'd0, core_rst}, 32'd1);
        check("t6_ready", {31'd0, imem_ready}, 32'd0);
        check("t6_rdata_nop", imem_rdata, 32'h0000_0013);
        send_word(32'd1);
        send_word(32'h0BAD_F00D);
        check("t6_core_rst_run", {31'd0, core_rst}, 32'd0);
        fetch(16'h0000);
        check("t6_w0_new", imem_rdata, 32'h0BAD_F00D);
        fetch(16'h0004);
        check("t6_w1_kept", imem_rdata, 32'hA000_0001);
        fetch(16'h0008);
        check("t6_w2_kept", imem_rdata, 32'hA000_0002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
